// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/write-back bundle for the multi-port register file.
// The master side drives ports and allocation; the slave returns read data and busy.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  alloc;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  flush;

  modport master (
    output we, waddr, wdata,
    output re, raddr,
    output alloc, alloc_addr, flush,
    input  rdata, rbusy
  );

  modport slave (
    input  we, waddr, wdata,
    input  re, raddr,
    input  alloc, alloc_addr, flush,
    output rdata, rbusy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with write bypass and a per-register
// pending bit so decode can see in-flight producers.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic      clk,
  input  logic      rst,
  regfile_mp_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;
  logic [NREG-1:0]   wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NWR; i++) begin
      if (bus.we[i])
        wr_hit[bus.waddr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // flush beats alloc, alloc beats a same-cycle write-back
  always_comb begin
    pend_nxt = pend;
    for (int r = 0; r < NREG; r++) begin
      if (bus.flush)
        pend_nxt[r] = 1'b0;
      else if (bus.alloc && bus.alloc_addr == ADDR_W'(r))
        pend_nxt[r] = 1'b1;
      else if (wr_hit[r])
        pend_nxt[r] = 1'b0;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.we[i] && bus.waddr[i*ADDR_W +: ADDR_W] != '0)
          regs[bus.waddr[i*ADDR_W +: ADDR_W]] <= bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = bus.raddr[j*ADDR_W +: ADDR_W];
      d  = '0;
      b  = 1'b0;
      if (rst && bus.re[j] && ra != '0) begin
        d = regs[ra];
        b = pend[ra];
        for (int i = 0; i < NWR; i++) begin
          if (bus.we[i] && bus.waddr[i*ADDR_W +: ADDR_W] == ra) begin
            d = bus.wdata[i*DATA_W +: DATA_W];
            b = 1'b0;
          end
        end
      end
      bus.rdata[j*DATA_W +: DATA_W] = d;
      bus.rbusy[j] = b;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors; expected reads are queued at issue
// and checked by a negedge monitor.
module tb_regfile_mp;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  regfile_mp_if #(
    .DATA_W(DW), .ADDR_W(AW),
    .NRD(NRD), .NWR(NWR)
  ) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW),
    .NRD(NRD), .NWR(NWR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [DW-1:0] gd;
      logic          gb;
      e  = q.pop_front();
      gd = bus.rdata[e.port*DW +: DW];
      gb = bus.rbusy[e.port];
      n_cmp++;
      if (gd !== e.data || gb !== e.busy) begin
        n_bad++;
        $display("FAIL %s p%0d: got %h/%b want %h/%b",
                 e.name, e.port, gd, gb, e.data, e.busy);
      end
    end
  end

  task automatic chk(input int p, input logic [DW-1:0] d,
                     input logic b, input string nm);
    exp_t e;
    e.port = p;
    e.data = d;
    e.busy = b;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic clr();
    bus.we         = '0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.re         = '0;
    bus.raddr      = '0;
    bus.alloc      = 1'b0;
    bus.alloc_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic wr(input int i, input int a, input logic [DW-1:0] d);
    bus.we[i] = 1'b1;
    bus.waddr[i*AW +: AW] = AW'(a);
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic rd(input int j, input int a);
    bus.re[j] = 1'b1;
    bus.raddr[j*AW +: AW] = AW'(a);
  endtask

  task automatic al(input int a);
    bus.alloc = 1'b1;
    bus.alloc_addr = AW'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b0;
    step();

    // reset held with writes/alloc pending on the bus
    repeat (3) begin
      clr();
      wr(0, 3, '1);
      wr(1, 5, '1);
      al(3);
      rd(0, 3);
      rd(1, 5);
      chk(0, 32'h0, 1'b0, "rst_r3");
      chk(1, 32'h0, 1'b0, "rst_r5");
      step();
    end
    rst = 1'b1;
    clr();
    rd(0, 3);
    rd(1, 5);
    chk(0, 32'h0, 1'b0, "post_rst_r3");
    chk(1, 32'h0, 1'b0, "post_rst_r5");
    step();

    // write + bypass, then storage; disabled port reads 0
    clr();
    wr(0, 7, 32'hDEADBEEF);
    rd(0, 7);
    chk(0, 32'hDEADBEEF, 1'b0, "byp_r7");
    step();
    clr();
    rd(0, 7);
    bus.raddr[1*AW +: AW] = AW'(7);
    chk(0, 32'hDEADBEEF, 1'b0, "store_r7");
    chk(1, 32'h0, 1'b0, "re0_r7");
    step();

    // collision: port 1 wins
    clr();
    wr(0, 9, 32'h11111111);
    wr(1, 9, 32'h22222222);
    rd(0, 9);
    rd(1, 9);
    chk(0, 32'h22222222, 1'b0, "coll_byp0");
    chk(1, 32'h22222222, 1'b0, "coll_byp1");
    step();
    clr();
    rd(0, 9);
    rd(1, 9);
    chk(0, 32'h22222222, 1'b0, "coll_st0");
    chk(1, 32'h22222222, 1'b0, "coll_st1");
    step();

    // register 0
    clr();
    wr(0, 0, 32'hFFFFFFFF);
    rd(0, 0);
    rd(1, 0);
    chk(0, 32'h0, 1'b0, "r0_wr_p0");
    chk(1, 32'h0, 1'b0, "r0_wr_p1");
    step();
    clr();
    al(0);
    rd(0, 0);
    rd(1, 0);
    chk(0, 32'h0, 1'b0, "r0_al_p0");
    chk(1, 32'h0, 1'b0, "r0_al_p1");
    step();
    clr();
    rd(0, 0);
    rd(1, 0);
    chk(0, 32'h0, 1'b0, "r0_after_p0");
    chk(1, 32'h0, 1'b0, "r0_after_p1");
    step();

    // scoreboard: alloc r4, busy until write-back three edges later
    clr();
    al(4);
    rd(0, 4);
    chk(0, 32'h0, 1'b0, "sb_pre");
    step();
    for (int k = 0; k < 2; k++) begin
      clr();
      rd(0, 4);
      rd(1, 4);
      chk(0, 32'h0, 1'b1, "sb_busy0");
      chk(1, 32'h0, 1'b1, "sb_busy1");
      step();
    end
    clr();
    wr(1, 4, 32'h55);
    rd(0, 4);
    chk(0, 32'h55, 1'b0, "sb_wb_byp");
    step();
    clr();
    rd(0, 4);
    chk(0, 32'h55, 1'b0, "sb_wb_st");
    step();
    // alloc and write-back together: pending stays set
    clr();
    al(4);
    wr(0, 4, 32'h66);
    rd(1, 4);
    chk(1, 32'h66, 1'b0, "sb_alwr_byp");
    step();
    clr();
    rd(1, 4);
    chk(1, 32'h66, 1'b1, "sb_alwr_st");
    step();
    clr();
    wr(0, 4, 32'h77);
    rd(1, 4);
    chk(1, 32'h77, 1'b0, "sb_wb2_byp");
    step();
    clr();
    rd(1, 4);
    chk(1, 32'h77, 1'b0, "sb_wb2_st");
    step();

    // flush
    clr();
    al(1);
    step();
    clr();
    al(2);
    step();
    clr();
    al(3);
    rd(0, 1);
    rd(1, 2);
    chk(0, 32'h0, 1'b1, "fl_pend_r1");
    chk(1, 32'h0, 1'b1, "fl_pend_r2");
    step();
    clr();
    bus.flush = 1'b1;
    al(6);
    wr(0, 2, 32'h0000ABCD);
    rd(0, 3);
    rd(1, 2);
    chk(0, 32'h0, 1'b1, "fl_cyc_r3");
    chk(1, 32'h0000ABCD, 1'b0, "fl_cyc_r2");
    step();
    clr();
    rd(0, 1);
    rd(1, 2);
    chk(0, 32'h0, 1'b0, "fl_post_r1");
    chk(1, 32'h0000ABCD, 1'b0, "fl_post_r2");
    step();
    clr();
    rd(0, 3);
    rd(1, 6);
    chk(0, 32'h0, 1'b0, "fl_post_r3");
    chk(1, 32'h0, 1'b0, "fl_post_r6");
    step();

    // mid-operation reset clears outputs and storage
    rst = 1'b0;
    clr();
    wr(0, 7, '1);
    rd(0, 7);
    rd(1, 9);
    chk(0, 32'h0, 1'b0, "mrst_r7");
    chk(1, 32'h0, 1'b0, "mrst_r9");
    step();
    rst = 1'b1;
    clr();
    rd(0, 7);
    rd(1, 9);
    chk(0, 32'h0, 1'b0, "mrst_st_r7");
    chk(1, 32'h0, 1'b0, "mrst_st_r9");
    step();

    clr();
    step();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
